// File: rtl/div_frec_pkg.sv
// -----------------------------------------------------------------------------
// div_frec_pkg
// Shared constants and helpers for the div_frec_clk clock divider.
//   WIDTH      : default width of divisor and counter
//   DIV_MIN    : smallest legal divisor (values below are clamped up)
//   div_clamp  : max(v, DIV_MIN)
//   div_half   : n >> 1, the length of the high phase
// The helpers work on a 64-bit carrier so any WIDTH up to 64 can use them
// with an explicit size cast at the call site.
// -----------------------------------------------------------------------------
package div_frec_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned DIV_MIN   = 2;
  localparam int unsigned CARRIER_W = 64;

  function automatic logic [CARRIER_W-1:0] div_clamp(input logic [CARRIER_W-1:0] v);
    if (v < CARRIER_W'(DIV_MIN)) begin
      return CARRIER_W'(DIV_MIN);
    end
    return v;
  endfunction

  function automatic logic [CARRIER_W-1:0] div_half(input logic [CARRIER_W-1:0] n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/div_frec_cnt.sv
// -----------------------------------------------------------------------------
// div_frec_cnt
// Modulo-N up counter (0..N-1) with enable and synchronous clear.
// Ports:
//   clk_in  : system clock, rising edge
//   reset_n : asynchronous active-low reset (cnt -> 0)
//   en      : advance the counter by one when high
//   clr     : synchronous clear to 0, wins over en
//   n       : modulus N (caller guarantees N >= 2)
//   cnt     : current count
//   wrap    : high while cnt == N-1 (the next enabled edge wraps to 0)
// -----------------------------------------------------------------------------
module div_frec_cnt
  import div_frec_pkg::*;
#(
  parameter int unsigned WIDTH = div_frec_pkg::WIDTH
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  // cnt never exceeds N-1, so a plain equality is enough to detect the wrap.
  assign wrap = (cnt == (n - WIDTH'(1)));

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/div_frec_clk.sv
// -----------------------------------------------------------------------------
// div_frec_clk
// Programmable clock divider producing a near-50%-duty square wave clk_out.
// Period is N clk_in cycles: high for N>>1 cycles, low for the rest.
// Ports:
//   clk_in  : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   en      : count enable; when low all state holds
//   div_ld  : load strobe for a new divisor (wins over en)
//   div_val : new divisor, sampled on div_ld; 0 and 1 clamp to 2
//   clk_out : divided clock, registered
//   tick    : one-cycle pulse coincident with each clk_out rise
// Configuration:
//   DIV_FREC_TICK_EN defined   -> tick is a real flop
//   DIV_FREC_TICK_EN undefined -> tick is tied to 0
// -----------------------------------------------------------------------------
module div_frec_clk
  import div_frec_pkg::*;
#(
  parameter int unsigned      WIDTH       = div_frec_pkg::WIDTH,
  parameter logic [WIDTH-1:0] DIV_DEFAULT = WIDTH'(50_000_000)
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             div_ld,
  input  logic [WIDTH-1:0] div_val,
  output logic             clk_out,
  output logic             tick
);

  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] cnt;
  logic             wrap;
  logic             fall_pt;

  assign half    = WIDTH'(div_half(CARRIER_W'(div_reg)));
  // H >= 1 because N >= 2, so H-1 never underflows.
  assign fall_pt = (cnt == (half - WIDTH'(1)));

  // A load restarts the period from cnt = 0 regardless of en.
  div_frec_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .en      (en),
    .clr     (div_ld),
    .n       (div_reg),
    .cnt     (cnt),
    .wrap    (wrap)
  );

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      div_reg <= DIV_DEFAULT;
      clk_out <= 1'b0;
    end else if (div_ld) begin
      div_reg <= WIDTH'(div_clamp(CARRIER_W'(div_val)));
      clk_out <= 1'b0;
    end else if (en) begin
      // Wrap takes precedence: for N=2 both points coincide only at cnt=0
      // vs cnt=1, but keeping the priority explicit avoids surprises.
      if (wrap) begin
        clk_out <= 1'b1;
      end else if (fall_pt) begin
        clk_out <= 1'b0;
      end
    end
  end

`ifdef DIV_FREC_TICK_EN
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      tick <= 1'b0;
    end else if (div_ld) begin
      tick <= 1'b0;
    end else begin
      tick <= en & wrap;
    end
  end
`else
  assign tick = 1'b0;
`endif

endmodule

// File: tb/tb_div_frec_clk.sv
// -----------------------------------------------------------------------------
// tb_div_frec_clk
// Directed bench for div_frec_clk with DIV_DEFAULT = 4. Expected waveforms are
// written as strings, one character per clk_in edge ('1' = high), and pushed
// into an expected queue before each run; outputs are sampled 1 ns after the
// rising edge. Expected tick follows the same DIV_FREC_TICK_EN setting as the
// design and is all zeros when the macro is undefined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_div_frec_clk;

  localparam int unsigned W = 32;

  logic         clk_in;
  logic         reset_n;
  logic         en;
  logic         div_ld;
  logic [W-1:0] div_val;
  logic         clk_out;
  logic         tick;

  int checks   = 0;
  int failures = 0;

  // {clk_out, tick} expected per edge
  logic [1:0] exp_q[$];

  div_frec_clk #(
    .WIDTH       (W),
    .DIV_DEFAULT (W'(4))
  ) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .en      (en),
    .div_ld  (div_ld),
    .div_val (div_val),
    .clk_out (clk_out),
    .tick    (tick)
  );

  // ---------------- clock / reset ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One rising edge, then sample and compare against the head of exp_q.
  task automatic edge_check(input string tag);
    logic [1:0] e;
    @(posedge clk_in);
    #1;
    e = exp_q.pop_front();
    check({tag, ".clk_out"}, 32'(clk_out), 32'(e[1]));
    check({tag, ".tick"},    32'(tick),    32'(e[0]));
  endtask

  // Run one edge per character of clk_s with the current en/div_ld inputs.
  task automatic run_vec(input string tag, input string clk_s, input string tick_s);
    for (int i = 0; i < clk_s.len(); i++) begin
      logic t;
`ifdef DIV_FREC_TICK_EN
      t = (tick_s[i] == "1");
`else
      t = 1'b0;
`endif
      exp_q.push_back({(clk_s[i] == "1"), t});
    end
    for (int i = 0; i < clk_s.len(); i++) begin
      edge_check($sformatf("%s[%0d]", tag, i + 1));
    end
  endtask

  // Load edge: clk_out and tick must both be 0 afterwards.
  task automatic do_load(input string tag, input logic [W-1:0] val, input logic en_v);
    div_ld  = 1'b1;
    div_val = val;
    en      = en_v;
    exp_q.push_back(2'b00);
    edge_check(tag);
    div_ld  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    en      = 1'b1;
    div_ld  = 1'b0;
    div_val = '0;

    repeat (2) @(posedge clk_in);
    #1;
    check("reset.clk_out", 32'(clk_out), 32'd0);
    check("reset.tick",    32'(tick),    32'd0);
    reset_n = 1'b1;

    // N=4 from reset, 20 edges: rise on edge 4, then high 2 / low 2.
    run_vec("n4", "00011001100110011001", "00010001000100010001");
    run_vec("n4b", "1", "0");  // now mid high phase (cnt=1)

    // Load 5 mid-period: drop on load edge, rise 5 edges later, high 2 / low 3.
    do_load("ld5", W'(5), 1'b1);
    run_vec("n5", "0000110001", "0000100001");

    // Divisors 0 and 1 clamp to 2: toggle every edge, starting low.
    do_load("ld0", W'(0), 1'b1);
    run_vec("n0", "010101", "010101");
    do_load("ld1", W'(1), 1'b1);
    run_vec("n1", "010101", "010101");

    // en low for 3 edges during the high phase: high lasts 5 edges, no tick.
    do_load("ld4", W'(4), 1'b1);
    run_vec("hold_a", "0001", "0001");
    en = 1'b0;
    run_vec("hold_b", "111", "000");
    en = 1'b1;
    run_vec("hold_c", "1001", "0001");

    // Load with en low: load wins, counter stays frozen at 0 until enabled.
    do_load("ld4_dis", W'(4), 1'b0);
    run_vec("frz_a", "00", "00");
    en = 1'b1;
    run_vec("frz_b", "0001", "0001");

    // Asynchronous reset while clk_out=1 and tick=1, between edges.
    reset_n = 1'b0;
    #2;
    check("areset.clk_out", 32'(clk_out), 32'd0);
    check("areset.tick",    32'(tick),    32'd0);
    #1;
    reset_n = 1'b1;
    run_vec("post_rst", "00011", "00010");

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL exp_q_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_frec_clk.md
# div_frec_clk

Programmable clock-enable/clock divider producing a slow, near-50%-duty square wave `clk_out` from the system clock. It feeds slow state machines and counters (for example, a progressive 0–15 counter FSM) with a human-visible stepping rate. The divisor is a parameter default that can be reloaded at run time. An optional one-cycle `tick` strobe marks each `clk_out` rising edge.

## Interface
- `WIDTH`, 32: width of the divisor and internal counter.
- `DIV_DEFAULT`, 50_000_000: divisor after reset (1 Hz from 50 MHz). Must satisfy 2 ≤ value < 2^WIDTH.

Ports:
- `clk_in` input 1: single system clock. All logic is on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `en` input 1: count enable. When low, all state holds.
- `div_ld` input 1: load strobe for a new divisor.
- `div_val` input WIDTH: new divisor, sampled when `div_ld`=1.
- `clk_out` output 1: divided clock, registered.
- `tick` output 1: one-`clk_in`-cycle pulse coincident with each `clk_out` rise. Exists only with `DIV_FREC_TICK_EN`; see Configuration.

## Operation
- State:
  - `div_reg` (WIDTH) holds the active divisor N.
  - `cnt` (WIDTH) counts 0..N-1.
  - `H = N >> 1` is recomputed combinationally from `div_reg`.
- Reset (`reset_n`=0, asynchronous):
  - `div_reg = DIV_DEFAULT`, `cnt = 0`, `clk_out = 0`, `tick = 0`.
- Each `clk_in` edge, in priority order:
  1. `div_ld`=1 (regardless of `en`):
     - `div_reg <= max(div_val, 2)`; values 0 and 1 clamp to 2.
     - `cnt <= 0`, `clk_out <= 0`, `tick <= 0`.
  2. `en`=0: hold `cnt` and `clk_out`; `tick <= 0`.
  3. `en`=1:
     - `cnt <= (cnt == N-1) ? 0 : cnt + 1`.
     - If `cnt == N-1`: `clk_out <= 1`, `tick <= 1`.
     - Else if `cnt == H-1`: `clk_out <= 0`, `tick <= 0`.
     - Otherwise `clk_out` holds and `tick <= 0`.
- Resulting waveform:
  - Period is N `clk_in` cycles.
  - High for H cycles, low for N-H cycles.
  - Exact 50% duty for even N; odd N is low one cycle longer.
- Arithmetic: comparisons are unsigned and WIDTH wide. `cnt` never exceeds N-1, so there is no overflow path.

## Timing
- After reset release with `en`=1, the first `clk_out` rise is registered on the N-th `clk_in` edge.
- N=2 gives the alternating pattern 0,1,0,1 starting with 0 after edge 1.
- Divisor load takes effect on the load edge. The next `clk_out` rise follows exactly N_new enabled edges later.
- `en` deasserted mid-period stretches the current phase by the number of disabled cycles. No phase reset.
- Reset asserted mid-period forces `clk_out` low immediately (asynchronous). The sequence restarts from `cnt` = 0 after release.
- `div_ld` and `en`=0 in the same cycle: the load wins, and the counter then stays frozen at 0.
- Every output is a flop. There is no combinational path from any input to any output.

## Configuration
- `DIV_FREC_TICK_EN` defined: the `tick` port and its flop are present, with behaviour as above.
- Not defined: the `tick` port remains and is driven constant 0. No tick logic is synthesized.

## Structure
- Package `div_frec_pkg` holds:
  - the `WIDTH` default;
  - `DIV_MIN` = 2;
  - a function `div_clamp(v)` returning max(v, DIV_MIN);
  - a function `div_half(n)` returning n >> 1.
- One sub-module, `div_frec_cnt`: a modulo-N up counter with `en`, synchronous clear and a `wrap` flag (`cnt == N-1`).
- The top level instantiates `div_frec_cnt` and owns `div_reg`, `clk_out` and `tick`.

## Test plan
- Reset, `DIV_DEFAULT` overridden to 4, `en`=1 -> `clk_out` reads 0,0,0,1,1,0,0,1,1… on successive edges. With the macro on, `tick`=1 on edges 4, 8, 12.
- Load `div_val`=5 mid-period -> `clk_out` drops to 0 on the load edge, rises 5 edges later, and is then high 2 / low 3.
- Load `div_val`=0 and then `div_val`=1 -> both behave as N=2, and `clk_out` toggles every edge.
- `en`=0 for 3 cycles while `clk_out`=1 with N=4 -> the high phase lasts 5 cycles and `tick` stays 0 throughout.
- Assert `reset_n`=0 between clock edges while `clk_out`=1 -> `clk_out` goes to 0 without a clock edge. After release, the first rise comes at edge N.
- Macro undefined, N=4, 20 cycles -> `tick` is constantly 0 and the `clk_out` waveform is identical to scenario 1.
